// File: rtl/arm7_data_memory.sv
// Byte-addressable little-endian data memory for the ARM7 load/store path.
// Independent word/byte write and read ports; read results are registered and held.
module arm7_data_memory #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_word_en,
  input  logic        write_byte_en,
  input  logic        read_word_en,
  input  logic        read_byte_en,
  input  logic [31:0] write_word_address,
  input  logic [31:0] write_byte_address,
  input  logic [31:0] write_word_data,
  input  logic [7:0]  write_byte_data,
  input  logic [31:0] read_word_address,
  input  logic [31:0] read_byte_address,
  output logic [31:0] read_word_data,
  output logic [7:0]  read_byte_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [7:0] mem [DEPTH];

  logic [ADDR_BITS-3:0] ww_word;
  logic [ADDR_BITS-3:0] rw_word;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [ADDR_BITS-1:0] rb_addr;

  // Upper address bits are dropped so accesses wrap modulo capacity; word
  // accesses also drop [1:0] to force alignment.
  assign ww_word = write_word_address[ADDR_BITS-1:2];
  assign rw_word = read_word_address[ADDR_BITS-1:2];
  assign wb_addr = write_byte_address[ADDR_BITS-1:0];
  assign rb_addr = read_byte_address[ADDR_BITS-1:0];

  // Byte write is issued after the word write so it wins on an overlapping byte.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (write_word_en) begin
        mem[{ww_word, 2'd0}] <= write_word_data[7:0];
        mem[{ww_word, 2'd1}] <= write_word_data[15:8];
        mem[{ww_word, 2'd2}] <= write_word_data[23:16];
        mem[{ww_word, 2'd3}] <= write_word_data[31:24];
      end
      if (write_byte_en) begin
        mem[wb_addr] <= write_byte_data;
      end
    end
  end

  // Read stage: non-blocking capture yields read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_word_data <= 32'h0;
      read_byte_data <= 8'h0;
    end else begin
      if (read_word_en) begin
        read_word_data <= {mem[{rw_word, 2'd3}], mem[{rw_word, 2'd2}],
                           mem[{rw_word, 2'd1}], mem[{rw_word, 2'd0}]};
      end
      if (read_byte_en) begin
        read_byte_data <= mem[rb_addr];
      end
    end
  end

endmodule

// File: tb/tb_arm7_data_memory.sv
// Directed self-checking bench for arm7_data_memory.
// Each step drives inputs, clocks once, and checks outputs 1 time unit after the edge.
module tb_arm7_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_word_en, write_byte_en, read_word_en, read_byte_en;
  logic [31:0] write_word_address, write_byte_address, read_word_address, read_byte_address;
  logic [31:0] write_word_data;
  logic [7:0]  write_byte_data;
  logic [31:0] read_word_data;
  logic [7:0]  read_byte_data;

  int n_cmp = 0;
  int n_err = 0;

  arm7_data_memory #(.ADDR_BITS(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .write_word_en      (write_word_en),
    .write_byte_en      (write_byte_en),
    .read_word_en       (read_word_en),
    .read_byte_en       (read_byte_en),
    .write_word_address (write_word_address),
    .write_byte_address (write_byte_address),
    .write_word_data    (write_word_data),
    .write_byte_data    (write_byte_data),
    .read_word_address  (read_word_address),
    .read_byte_address  (read_byte_address),
    .read_word_data     (read_word_data),
    .read_byte_data     (read_byte_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, then drop all enables.
  task automatic cyc();
    @(posedge clk);
    #1;
    write_word_en = 1'b0;
    write_byte_en = 1'b0;
    read_word_en  = 1'b0;
    read_byte_en  = 1'b0;
  endtask

  task automatic ww(input logic [31:0] a, input logic [31:0] d);
    write_word_en = 1'b1; write_word_address = a; write_word_data = d;
    cyc();
  endtask

  task automatic wb(input logic [31:0] a, input logic [7:0] d);
    write_byte_en = 1'b1; write_byte_address = a; write_byte_data = d;
    cyc();
  endtask

  task automatic rw(input logic [31:0] a);
    read_word_en = 1'b1; read_word_address = a;
    cyc();
  endtask

  task automatic rb(input logic [31:0] a);
    read_byte_en = 1'b1; read_byte_address = a;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    write_word_en = 1'b0; write_byte_en = 1'b0;
    read_word_en  = 1'b0; read_byte_en  = 1'b0;
    write_word_address = '0; write_byte_address = '0;
    read_word_address  = '0; read_byte_address  = '0;
    write_word_data = '0; write_byte_data = '0;

    cyc(); cyc();
    chk("reset_word", read_word_data, 32'h0);
    chk("reset_byte", {24'h0, read_byte_data}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Basic word write/read and hold
    ww(32'h1000, 32'hDEADBEEF);
    rw(32'h1000);
    chk("word_rd", read_word_data, 32'hDEADBEEF);
    cyc();
    chk("word_hold", read_word_data, 32'hDEADBEEF);

    // Byte merge into existing word
    wb(32'h1001, 8'hAA);
    wb(32'h1003, 8'h55);
    rb(32'h1001);
    chk("byte_rd_1001", {24'h0, read_byte_data}, 32'hAA);
    rb(32'h1003);
    chk("byte_rd_1003", {24'h0, read_byte_data}, 32'h55);
    rw(32'h1000);
    chk("byte_merge", read_word_data, 32'h55ADAAEF);

    // Little-endian layout and misaligned word read
    ww(32'h2000, 32'h11223344);
    rb(32'h2000); chk("le_b0", {24'h0, read_byte_data}, 32'h44);
    rb(32'h2001); chk("le_b1", {24'h0, read_byte_data}, 32'h33);
    rb(32'h2002); chk("le_b2", {24'h0, read_byte_data}, 32'h22);
    rb(32'h2003); chk("le_b3", {24'h0, read_byte_data}, 32'h11);
    cyc();
    chk("byte_hold", {24'h0, read_byte_data}, 32'h11);
    rw(32'h2002);
    chk("misaligned_word", read_word_data, 32'h11223344);

    // Both read ports in the same cycle
    read_word_en = 1'b1; read_word_address = 32'h1000;
    read_byte_en = 1'b1; read_byte_address = 32'h2001;
    cyc();
    chk("dual_rd_word", read_word_data, 32'h55ADAAEF);
    chk("dual_rd_byte", {24'h0, read_byte_data}, 32'h33);

    // Read-before-write on the word port
    ww(32'h3000, 32'h0);
    write_word_en = 1'b1; write_word_address = 32'h3000; write_word_data = 32'hCAFEF00D;
    read_word_en  = 1'b1; read_word_address  = 32'h3000;
    cyc();
    chk("rbw_word_old", read_word_data, 32'h0);
    rw(32'h3000);
    chk("rbw_word_new", read_word_data, 32'hCAFEF00D);

    // Read-before-write on the byte port
    wb(32'h5000, 8'h77);
    write_byte_en = 1'b1; write_byte_address = 32'h5000; write_byte_data = 8'h88;
    read_byte_en  = 1'b1; read_byte_address  = 32'h5000;
    cyc();
    chk("rbw_byte_old", {24'h0, read_byte_data}, 32'h77);
    rb(32'h5000);
    chk("rbw_byte_new", {24'h0, read_byte_data}, 32'h88);

    // Word/byte write collision: byte wins its lane
    write_word_en = 1'b1; write_word_address = 32'h4000; write_word_data = 32'hFFFFFFFF;
    write_byte_en = 1'b1; write_byte_address = 32'h4002; write_byte_data = 8'h12;
    cyc();
    rw(32'h4000);
    chk("collision", read_word_data, 32'hFF12FFFF);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_word", read_word_data, 32'h0);
    chk("async_rst_byte", {24'h0, read_byte_data}, 32'h0);
    // Accesses while in reset are ignored
    write_word_en = 1'b1; write_word_address = 32'h2000; write_word_data = 32'hBAD0BAD0;
    read_word_en  = 1'b1; read_word_address  = 32'h2000;
    read_byte_en  = 1'b1; read_byte_address  = 32'h2000;
    cyc();
    chk("rst_hold_word", read_word_data, 32'h0);
    chk("rst_hold_byte", {24'h0, read_byte_data}, 32'h0);
    rst_n = 1'b1;
    cyc();

    rw(32'h2000);
    chk("mem_survives_rst", read_word_data, 32'h11223344);

    // Address wrap modulo 64 KiB
    ww(32'h00011000, 32'h13579BDF);
    rw(32'h00001000);
    chk("wrap_word", read_word_data, 32'h13579BDF);
    rb(32'h00FF1002);
    chk("wrap_byte", {24'h0, read_byte_data}, 32'h57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arm7_data_memory.md
Name: arm7_data_memory

Overview:
Byte-addressable, little-endian data memory for the ARM7 core's load/store path. It has independent word and byte write ports and independent word and byte read ports, all synchronous to one clock. Read data is registered and held until the next enabled read. The block sits behind the core's memory stage and serves LDR/STR and LDRB/STRB.

Parameters:
ADDR_BITS, 16, number of significant byte-address bits; capacity = 2^ADDR_BITS bytes (64 KiB default).

Ports:
clk  input  1  system clock; all writes and reads act on the rising edge
rst_n  input  1  asynchronous active-low reset
write_word_en  input  1  write 32-bit word this cycle
write_byte_en  input  1  write 8-bit byte this cycle
read_word_en  input  1  capture 32-bit word into read_word_data this cycle
read_byte_en  input  1  capture 8-bit byte into read_byte_data this cycle
write_word_address  input  32  byte address for word write
write_byte_address  input  32  byte address for byte write
write_word_data  input  32  word write data
write_byte_data  input  8  byte write data
read_word_address  input  32  byte address for word read
read_byte_address  input  32  byte address for byte read
read_word_data  output  32  registered word read result
read_byte_data  output  8  registered byte read result

Behaviour:
- Storage: 2^ADDR_BITS bytes. Address bits above ADDR_BITS-1 are ignored, so addresses wrap modulo capacity.
- Little-endian layout: the word at aligned address A is {mem[A+3], mem[A+2], mem[A+1], mem[A]}. mem[A] maps to bits [7:0].
- Word accesses ignore address bits [1:0] and are forced to 4-byte alignment. There is no rotation and no fault on misaligned addresses.
- Byte accesses use the full byte address; any byte is reachable.
- Word write: on posedge clk with write_word_en=1, all 4 bytes of the aligned word are updated.
- Byte write: on posedge clk with write_byte_en=1, only the addressed byte is updated. The other 3 bytes of its word are unchanged.
- Simultaneous word and byte write to an overlapping byte in the same cycle: the byte write wins for that byte. The word write still updates the remaining bytes.
- Word read: on posedge clk with read_word_en=1, read_word_data <= the addressed word. Result is visible after that edge (1-cycle latency).
- Byte read: on posedge clk with read_byte_en=1, read_byte_data <= the addressed byte. Same 1-cycle latency.
- With a read enable low, the corresponding output holds its last value indefinitely.
- Read and write to the same location in the same cycle: read-before-write. The output gets the old contents; the new data is readable from the next cycle.
- Word and byte read ports are fully independent and may both fire in the same cycle.
- Reset: rst_n low asynchronously forces read_word_data=32'h0 and read_byte_data=8'h0. Outputs stay 0 while rst_n is low.
- Memory array contents are not cleared by reset and power up undefined (X in simulation).
- Writes and reads are ignored while rst_n is low. Normal operation resumes at the first rising edge after deassertion.

Test Plan:
- Word write/read: write 0xDEADBEEF @0x1000; read word @0x1000 -> read_word_data=0xDEADBEEF one cycle after the enabled edge, and still 0xDEADBEEF one further cycle after read_word_en drops.
- Byte merge: after the above, byte-write 0xAA @0x1001 and 0x55 @0x1003. Byte reads @0x1001 -> 0xAA and @0x1003 -> 0x55; word read @0x1000 -> 0x55ADAABE... corrected: 0x55AD_AAEF.
- Endianness: word 0x11223344 @0x2000; byte reads @0x2000..0x2003 -> 0x44, 0x33, 0x22, 0x11. Word read @0x2002 (misaligned) -> 0x11223344.
- Read-before-write: word 0x0 @0x3000, then in one cycle write 0xCAFEF00D and read @0x3000 -> 0x00000000; next read -> 0xCAFEF00D.
- Collision: same cycle, word write 0xFFFFFFFF @0x4000 and byte write 0x12 @0x4002 -> word read 0xFF12FFFF.
- Reset/wrap: assert rst_n mid-test between edges -> both outputs 0 immediately. After release, word write @0x00011000 reads back @0x1000 with ADDR_BITS=16, and memory contents survive reset.
